// File: rtl/arb_scheduler.sv
// ---------------------------------------------------------------------------
// arb_scheduler
// 16-requester arbiter with selectable fixed-priority or round-robin
// selection, a bounded grant hold time and a forced-release timeout pulse.
//
// Parameters:
//   MAX_HOLD    - maximum consecutive GRANT cycles per grant (1..255)
//
// Ports:
//   clk         - clock, all state changes on the rising edge
//   rst_n       - asynchronous active-low reset
//   req[15:0]   - request lines, bit i belongs to requester i
//   mode        - 0: fixed priority (bit 15 wins), 1: round-robin
//   done        - one-cycle release pulse from the granted requester
//   grant[15:0] - registered one-hot grant, zero when idle
//   grant_idx   - registered binary index of the granted bit, 0 when idle
//   grant_valid - high exactly when grant is non-zero
//   timeout     - one-cycle pulse when a grant was released by the counter
// ---------------------------------------------------------------------------
module arb_scheduler #(
  parameter int MAX_HOLD = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        mode,
  input  logic        done,
  output logic [15:0] grant,
  output logic [3:0]  grant_idx,
  output logic        grant_valid,
  output logic        timeout
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t      r_state;
  logic [15:0] r_grant;
  logic [3:0]  r_grant_idx;
  logic        r_valid;
  logic        r_timeout;
  logic [7:0]  r_hold;
  logic [3:0]  r_last;

  state_t      w_state_nx;
  logic [15:0] w_grant_nx;
  logic [3:0]  w_grant_idx_nx;
  logic        w_valid_nx;
  logic        w_timeout_nx;
  logic [7:0]  w_hold_nx;
  logic [3:0]  w_last_nx;
  logic [3:0]  w_winner;
  logic        w_rel_done;
  logic        w_rel_drop;
  logic        w_rel_cnt;

  // Highest asserted request bit wins.
  function automatic logic [3:0] f_fixed_pick(input logic [15:0] req_v);
    logic [3:0] pick;
    pick = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (req_v[i]) begin
        pick = 4'(i);
      end
    end
    return pick;
  endfunction

  // Search downward from last-1 with wrap; last itself has lowest priority.
  // Iterating from the farthest candidate toward the nearest lets the
  // nearest asserted bit overwrite all others.
  function automatic logic [3:0] f_rr_pick(input logic [15:0] req_v,
                                           input logic [3:0]  last_v);
    logic [3:0] pick;
    logic [3:0] idx;
    pick = last_v;
    for (int k = 16; k >= 1; k--) begin
      idx = last_v - 4'(k);
      if (req_v[idx]) begin
        pick = idx;
      end
    end
    return pick;
  endfunction

  assign w_winner   = mode ? f_rr_pick(req, r_last) : f_fixed_pick(req);
  assign w_rel_done = done;
  assign w_rel_drop = ~req[r_grant_idx];
  assign w_rel_cnt  = (r_hold == 8'(MAX_HOLD));

  // Next-state and next-output logic.
  always_comb begin
    w_state_nx     = r_state;
    w_grant_nx     = r_grant;
    w_grant_idx_nx = r_grant_idx;
    w_valid_nx     = r_valid;
    w_timeout_nx   = 1'b0;
    w_hold_nx      = r_hold;
    w_last_nx      = r_last;
    case (r_state)
      IDLE: begin
        if (req != 16'h0000) begin
          w_state_nx     = GRANT;
          w_grant_nx     = 16'h0001 << w_winner;
          w_grant_idx_nx = w_winner;
          w_valid_nx     = 1'b1;
          w_hold_nx      = 8'd1;
          w_last_nx      = w_winner;
        end else begin
          w_state_nx     = IDLE;
          w_grant_nx     = 16'h0000;
          w_grant_idx_nx = 4'd0;
          w_valid_nx     = 1'b0;
          w_hold_nx      = 8'd0;
        end
      end
      GRANT: begin
        if (w_rel_done || w_rel_drop || w_rel_cnt) begin
          w_state_nx     = IDLE;
          w_grant_nx     = 16'h0000;
          w_grant_idx_nx = 4'd0;
          w_valid_nx     = 1'b0;
          w_hold_nx      = 8'd0;
          // Timeout only when the counter alone forced the release.
          w_timeout_nx   = w_rel_cnt & ~w_rel_done & ~w_rel_drop;
        end else begin
          w_hold_nx      = r_hold + 8'd1;
        end
      end
      default: begin
        w_state_nx     = IDLE;
        w_grant_nx     = 16'h0000;
        w_grant_idx_nx = 4'd0;
        w_valid_nx     = 1'b0;
        w_hold_nx      = 8'd0;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_grant     <= 16'h0000;
      r_grant_idx <= 4'd0;
      r_valid     <= 1'b0;
      r_timeout   <= 1'b0;
      r_hold      <= 8'd0;
      r_last      <= 4'd0;
    end else begin
      r_state     <= w_state_nx;
      r_grant     <= w_grant_nx;
      r_grant_idx <= w_grant_idx_nx;
      r_valid     <= w_valid_nx;
      r_timeout   <= w_timeout_nx;
      r_hold      <= w_hold_nx;
      r_last      <= w_last_nx;
    end
  end

  assign grant       = r_grant;
  assign grant_idx   = r_grant_idx;
  assign grant_valid = r_valid;
  assign timeout     = r_timeout;

endmodule
